// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result bundle for the sequential ALU.
// The master drives operands and the start request; the slave (alu_seq)
// returns the registered result, flags and the busy/done handshake.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic [2:0]       sel_in;
    logic             carry_in;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             zero_out;
    logic             busy;
    logic             done;

    modport master (
        output start, in_A, in_B, sel_in, carry_in,
        input  out, carry_out, zero_out, busy, done
    );

    modport slave (
        input  start, in_A, in_B, sel_in, carry_in,
        output out, carry_out, zero_out, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with multi-cycle SHL/SHR (one bit per clock).
// Optional build macro ALU_CARRY_CHAIN_EN: ADD, SUB and zero-count shifts
// take their carry from the internal carry_out register instead of carry_in.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_out, w_out_nxt;
    logic             r_carry, w_carry_nxt;
    logic             r_zero;
    logic             r_done, w_done_nxt;
    logic             r_dir, w_dir_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [CW-1:0]    r_n, w_n_nxt;
    logic [CW-1:0]    w_cnt_inc;
    logic [CW-1:0]    w_n;
    logic             w_load;
    logic             w_cin;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;

`ifdef ALU_CARRY_CHAIN_EN
    assign w_cin = r_carry;
`else
    assign w_cin = bus.carry_in;
`endif

    // Shift count clamped to WIDTH; compared in WIDTH+1 bits so any WIDTH works.
    assign w_n = ({1'b0, bus.in_B} >= (WIDTH + 1)'(WIDTH)) ? CW'(WIDTH)
                                                           : bus.in_B[CW-1:0];

    assign w_add     = {1'b0, bus.in_A} + {1'b0, bus.in_B}  + {{WIDTH{1'b0}}, w_cin};
    assign w_sub     = {1'b0, bus.in_A} + {1'b0, ~bus.in_B} + {{WIDTH{1'b0}}, w_cin};
    assign w_cnt_inc = r_cnt + CW'(1);

    // Next-state, next-result and done decode.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_carry_nxt = r_carry;
        w_done_nxt  = 1'b0;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_n_nxt     = r_n;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load     = 1'b1;
                    w_done_nxt = 1'b1;
                    case (bus.sel_in)
                        3'b000, 3'b001: begin
                            w_dir_nxt = bus.sel_in[0];
                            w_n_nxt   = w_n;
                            w_cnt_nxt = CW'(1);
                            if (w_n == '0) begin
                                w_out_nxt   = bus.in_A;
                                w_carry_nxt = w_cin;
                            end else begin
                                if (bus.sel_in[0]) begin
                                    w_out_nxt   = bus.in_A >> 1;
                                    w_carry_nxt = bus.in_A[0];
                                end else begin
                                    w_out_nxt   = bus.in_A << 1;
                                    w_carry_nxt = bus.in_A[WIDTH-1];
                                end
                                // A one-bit shift completes on the start edge itself.
                                if (w_n != CW'(1)) begin
                                    w_done_nxt  = 1'b0;
                                    w_state_nxt = S_SHIFT;
                                end
                            end
                        end
                        3'b010: {w_carry_nxt, w_out_nxt} = w_add;
                        3'b011: {w_carry_nxt, w_out_nxt} = w_sub;
                        3'b100: begin
                            w_out_nxt   = bus.in_A ^ bus.in_B;
                            w_carry_nxt = 1'b0;
                        end
                        3'b101: begin
                            w_out_nxt   = bus.in_A | bus.in_B;
                            w_carry_nxt = 1'b0;
                        end
                        3'b110: begin
                            w_out_nxt   = bus.in_A & bus.in_B;
                            w_carry_nxt = 1'b0;
                        end
                        default: begin
                            w_out_nxt   = bus.in_A;
                            w_carry_nxt = 1'b0;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                w_load    = 1'b1;
                w_cnt_nxt = w_cnt_inc;
                if (r_dir) begin
                    w_out_nxt   = r_out >> 1;
                    w_carry_nxt = r_out[0];
                end else begin
                    w_out_nxt   = r_out << 1;
                    w_carry_nxt = r_out[WIDTH-1];
                end
                if (w_cnt_inc == r_n) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, result and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
            r_n     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_dir   <= w_dir_nxt;
            r_cnt   <= w_cnt_nxt;
            r_n     <= w_n_nxt;
            r_out   <= w_out_nxt;
            r_carry <= w_carry_nxt;
            if (w_load) begin
                r_zero <= (w_out_nxt == '0);
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.carry_out = r_carry;
    assign bus.zero_out  = r_zero;
    assign bus.busy      = (r_state == S_SHIFT);
    assign bus.done      = r_done;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_seq;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic start_op(input logic [2:0] sel, input logic [7:0] a,
                            input logic [7:0] b, input logic cin);
        bus.sel_in   = sel;
        bus.in_A     = a;
        bus.in_B     = b;
        bus.carry_in = cin;
        bus.start    = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.out !== 8'h00) begin bad++; $display("FAIL rst_out got=%h exp=00", bus.out); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL rst_carry got=%b exp=0", bus.carry_out); end
        total++; if (bus.zero_out !== 1'b0) begin bad++; $display("FAIL rst_zero got=%b exp=0", bus.zero_out); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        reset = 1'b0;
    endtask

    task automatic test_add;
        logic [7:0] exp1;
`ifdef ALU_CARRY_CHAIN_EN
        exp1 = 8'h08;
`else
        exp1 = 8'h09;
`endif
        start_op(3'b010, 8'h05, 8'h03, 1'b1);
        @(negedge clk);
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL add1_done got=%b exp=1", bus.done); end
        total++; if (bus.out !== exp1) begin bad++; $display("FAIL add1_out got=%h exp=%h", bus.out, exp1); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL add1_carry got=%b exp=0", bus.carry_out); end
        total++; if (bus.zero_out !== 1'b0) begin bad++; $display("FAIL add1_zero got=%b exp=0", bus.zero_out); end
        start_op(3'b010, 8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL add2_done got=%b exp=1", bus.done); end
        total++; if (bus.out !== 8'h00) begin bad++; $display("FAIL add2_out got=%h exp=00", bus.out); end
        total++; if (bus.carry_out !== 1'b1) begin bad++; $display("FAIL add2_carry got=%b exp=1", bus.carry_out); end
        total++; if (bus.zero_out !== 1'b1) begin bad++; $display("FAIL add2_zero got=%b exp=1", bus.zero_out); end
    endtask

    task automatic test_sub;
        start_op(3'b011, 8'h06, 8'h03, 1'b1);
        @(negedge clk);
        total++; if (bus.out !== 8'h03) begin bad++; $display("FAIL sub1_out got=%h exp=03", bus.out); end
        total++; if (bus.carry_out !== 1'b1) begin bad++; $display("FAIL sub1_carry got=%b exp=1", bus.carry_out); end
        start_op(3'b011, 8'h03, 8'h06, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.out !== 8'hFD) begin bad++; $display("FAIL sub2_out got=%h exp=FD", bus.out); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL sub2_carry got=%b exp=0", bus.carry_out); end
        total++; if (bus.zero_out !== 1'b0) begin bad++; $display("FAIL sub2_zero got=%b exp=0", bus.zero_out); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] sels [4];
        logic [7:0] as   [4];
        logic [7:0] exps [4];
        sels = '{3'b100, 3'b101, 3'b110, 3'b111};
        as   = '{8'hCC, 8'hCC, 8'hCC, 8'h5A};
        exps = '{8'h66, 8'hEE, 8'h88, 8'h5A};
        bus.carry_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_op(sels[i], as[i], 8'hAA, 1'b1);
            @(negedge clk);
            total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done[%0d] got=%b exp=1", i, bus.done); end
            total++; if (bus.out !== exps[i]) begin bad++; $display("FAIL b2b_out[%0d] got=%h exp=%h", i, bus.out, exps[i]); end
            total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL b2b_carry[%0d] got=%b exp=0", i, bus.carry_out); end
        end
        bus.start = 1'b0;
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_done_end got=%b exp=0", bus.done); end
    endtask

    task automatic test_shl_ignore;
        start_op(3'b000, 8'h81, 8'h03, 1'b0);
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL shl_busy1 got=%b exp=1", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL shl_done1 got=%b exp=0", bus.done); end
        total++; if (bus.out !== 8'h02) begin bad++; $display("FAIL shl_out1 got=%h exp=02", bus.out); end
        total++; if (bus.carry_out !== 1'b1) begin bad++; $display("FAIL shl_carry1 got=%b exp=1", bus.carry_out); end
        start_op(3'b010, 8'h11, 8'h22, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL shl_busy2 got=%b exp=1", bus.busy); end
        total++; if (bus.out !== 8'h04) begin bad++; $display("FAIL shl_out2 got=%h exp=04", bus.out); end
        @(negedge clk);
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL shl_done3 got=%b exp=1", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL shl_busy3 got=%b exp=0", bus.busy); end
        total++; if (bus.out !== 8'h08) begin bad++; $display("FAIL shl_out3 got=%h exp=08", bus.out); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL shl_carry3 got=%b exp=0", bus.carry_out); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL shl_done4 got=%b exp=0", bus.done); end
        total++; if (bus.out !== 8'h08) begin bad++; $display("FAIL shl_noqueue got=%h exp=08", bus.out); end
    endtask

    task automatic test_shr_clamp;
        int edges;
        bit got;
        edges = 0;
        got   = 1'b0;
        start_op(3'b001, 8'h81, 8'h09, 1'b0);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            edges++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL shr_timeout got=%b exp=1", got); end
        total++; if (edges !== 8) begin bad++; $display("FAIL shr_latency got=%0d exp=8", edges); end
        total++; if (bus.out !== 8'h00) begin bad++; $display("FAIL shr_out got=%h exp=00", bus.out); end
        total++; if (bus.carry_out !== 1'b1) begin bad++; $display("FAIL shr_carry got=%b exp=1", bus.carry_out); end
        total++; if (bus.zero_out !== 1'b1) begin bad++; $display("FAIL shr_zero got=%b exp=1", bus.zero_out); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL shr_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_shift_zero;
        start_op(3'b000, 8'h3C, 8'h00, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL sh0_done got=%b exp=1", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sh0_busy got=%b exp=0", bus.busy); end
        total++; if (bus.out !== 8'h3C) begin bad++; $display("FAIL sh0_out got=%h exp=3C", bus.out); end
        total++; if (bus.carry_out !== 1'b1) begin bad++; $display("FAIL sh0_carry got=%b exp=1", bus.carry_out); end
        total++; if (bus.zero_out !== 1'b0) begin bad++; $display("FAIL sh0_zero got=%b exp=0", bus.zero_out); end
    endtask

    task automatic test_reset_mid_shift;
        bit seen_done;
        start_op(3'b000, 8'h0F, 8'h05, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rms_busy_pre got=%b exp=1", bus.busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (bus.out !== 8'h00) begin bad++; $display("FAIL rms_out got=%h exp=00", bus.out); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL rms_carry got=%b exp=0", bus.carry_out); end
        total++; if (bus.zero_out !== 1'b0) begin bad++; $display("FAIL rms_zero got=%b exp=0", bus.zero_out); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rms_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rms_done got=%b exp=0", bus.done); end
        seen_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done = 1'b1;
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL rms_late_done got=%b exp=0", seen_done); end
        start_op(3'b010, 8'h10, 8'h20, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL rms_add_done got=%b exp=1", bus.done); end
        total++; if (bus.out !== 8'h30) begin bad++; $display("FAIL rms_add_out got=%h exp=30", bus.out); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL rms_add_carry got=%b exp=0", bus.carry_out); end
    endtask

`ifdef ALU_CARRY_CHAIN_EN
    task automatic test_carry_chain;
        start_op(3'b010, 8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        total++; if (bus.carry_out !== 1'b1) begin bad++; $display("FAIL chain1_carry got=%b exp=1", bus.carry_out); end
        start_op(3'b010, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.out !== 8'h01) begin bad++; $display("FAIL chain2_out got=%h exp=01", bus.out); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL chain2_carry got=%b exp=0", bus.carry_out); end
    endtask
`endif

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.in_A     = 8'h00;
        bus.in_B     = 8'h00;
        bus.sel_in   = 3'b000;
        bus.carry_in = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_shl_ignore();
        test_shr_clamp();
        test_shift_zero();
        test_reset_mid_shift();
`ifdef ALU_CARRY_CHAIN_EN
        test_carry_chain();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU used in the HC8 datapath.
- Width is generic (default 8) and results, carry and zero flags are registered.
- Adds multi-cycle shift operations (SHL/SHR), one bit per clock, under a start/busy/done handshake.
- Sits between the register file and the accumulator write-back in the CPU core.

Parameters:
- WIDTH, 8, data width of in_A, in_B and out; must be >= 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- start  input  1  request pulse; operands and sel_in are captured on the edge where start=1 and busy=0.
- in_A  input  WIDTH  operand A.
- in_B  input  WIDTH  operand B; for shifts, it is the unsigned shift count.
- sel_in  input  3  operation select.
- carry_in  input  1  carry/borrow input.
- out  output  WIDTH  registered result.
- carry_out  output  1  registered carry flag.
- zero_out  output  1  registered flag; 1 when out==0 at completion.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse marking completion; out and flags are valid from this cycle until the next completion.

Behaviour:
- Reset: out=0, carry_out=0, zero_out=0, busy=0, done=0; shift counter cleared.
  - Reset has priority over start.
  - Reset mid-shift aborts the operation; no done pulse is issued.
- sel_in encoding:
  - 000 SHL, 001 SHR.
  - 010 ADD: {carry_out,out} = A + B + carry_in.
  - 011 SUB: {carry_out,out} = A + ~B + carry_in. carry_in=1 means no borrow in; carry_out=1 means no borrow out.
  - 100 XOR, 101 OR, 110 AND, 111 PASS (out=A).
  - Logic ops and PASS force carry_out=0.
- Arithmetic is computed in WIDTH+1 bits; carry is the MSB of that result; out is the low WIDTH bits.
- Single-cycle ops (010-111), accepted at edge E:
  - After E: out and flags hold the result, done=1 for exactly one cycle.
  - busy stays 0.
  - Back-to-back starts are allowed on every cycle.
- Shift ops, with n = min(in_B, WIDTH):
  - n=0: after E, out=A, carry_out=carry_in, done=1 for one cycle, busy stays 0.
  - n>=1: at E, out loads the first shifted value and busy=1. Each following edge shifts one more bit.
  - After the n-th edge (counting E as the first): busy=0 and done=1 for one cycle.
  - Latency is therefore n edges.
  - Zeros are shifted in. carry_out follows each bit shifted out; its final value is the last bit shifted out.
  - Counts >= WIDTH clamp to WIDTH, giving out=0 and carry_out = A[0] (SHL) or A[WIDTH-1] (SHR).
- Flags and out are intermediate while busy=1; consumers must sample only on done.
- start while busy=1 is ignored; the operation is not queued.
- zero_out is updated on every state-changing edge from the value loaded into out.
- FSM:
  - IDLE -> (start, single-cycle op or n=0) -> IDLE with done.
  - IDLE -> (start, shift with n>=1) -> SHIFT.
  - SHIFT -> (counter reaches n) -> IDLE with done.
  - Any state -> (reset) -> IDLE.

Optional Feature:
- Macro: ALU_CARRY_CHAIN_EN.
- Defined: ADD, SUB and n=0 shifts take carry from the internal carry_out register; the carry_in port is ignored. This enables multi-word add/sub chains without external feedback.
- Undefined: carry_in port is used as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- WIDTH=8, ADD A=0x05 B=0x03 cin=1 -> one cycle later done=1, out=0x09, carry_out=0, zero_out=0. Then ADD A=0xFF B=0x01 cin=0 -> out=0x00, carry_out=1, zero_out=1.
- SUB A=0x06 B=0x03 cin=1 -> out=0x03, carry_out=1. Then SUB A=0x03 B=0x06 cin=1 -> out=0xFD, carry_out=0.
- XOR/OR/AND with A=0xCC B=0xAA -> 0x66/0xEE/0x88, carry_out=0. PASS A=0x5A -> out=0x5A. Issue back-to-back starts and check done on every cycle.
- SHL A=0x81 B=3 -> busy high for 2 cycles after the start edge, done after edge 3, out=0x08, carry_out=0. A start pulse asserted mid-shift is ignored.
- SHR A=0x81 B=9 (clamped to 8) -> done after 8 edges, out=0x00, carry_out=1, zero_out=1. SHL with B=0 and cin=1 -> next cycle done, out=A, carry_out=1.
- Assert reset during edge 2 of an SHL by 5 -> next cycle all outputs 0, busy=0, no done pulse. A following ADD completes normally. With ALU_CARRY_CHAIN_EN defined: ADD 0xFF+0x01, then ADD 0x00+0x00 -> second result is out=0x01.
